// File: rtl/timing_control_unit_if.sv
// Control-side bundle of the timing/decode stage.
// The control sequencer drives the master side; the timing unit sits on the slave side.
interface timing_control_unit_if #(
  parameter int SC_WIDTH = 3,
  parameter int IR_WIDTH = 16
);
  localparam int T_WIDTH = 1 << SC_WIDTH;

  logic                start;
  logic                halt;
  logic                sc_clr;
  logic                ir_load;
  logic [IR_WIDTH-1:0] ir_in;

  logic [T_WIDTH-1:0]  T;
  logic [7:0]          D;
  logic                J;
  logic [11:0]         ir_addr;
  logic                running;
  logic                sc_overflow;

  modport master (
    output start, halt, sc_clr, ir_load, ir_in,
    input  T, D, J, ir_addr, running, sc_overflow
  );

  modport slave (
    input  start, halt, sc_clr, ir_load, ir_in,
    output T, D, J, ir_addr, running, sc_overflow
  );
endinterface

// File: rtl/timing_control_unit.sv
// Timing/decode stage: IR, start/stop flip-flop S and sequence counter SC,
// producing one-hot timing T, opcode decode D, indirect bit J and the address field.
module timing_control_unit #(
  parameter int SC_WIDTH = 3,
  parameter int IR_WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  timing_control_unit_if.slave bus
);
  localparam int T_WIDTH = 1 << SC_WIDTH;
  localparam logic [SC_WIDTH-1:0] SC_MAX = {SC_WIDTH{1'b1}};

  logic                s_q, s_d;
  logic [SC_WIDTH-1:0] sc_q, sc_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic                ovf_q, ovf_d;

  // Next-state logic; SC and IR look at registered S, so start only takes effect one edge later.
  always_comb begin
    s_d   = s_q;
    sc_d  = sc_q;
    ir_d  = ir_q;
    ovf_d = ovf_q;

    if (bus.halt) begin
      s_d = 1'b0;
    end else if (bus.start) begin
      s_d = 1'b1;
    end else begin
      s_d = s_q;
    end

    if (bus.halt || !s_q) begin
      sc_d = {SC_WIDTH{1'b0}};
    end else if (bus.sc_clr) begin
      sc_d = {SC_WIDTH{1'b0}};
    end else if (sc_q == SC_MAX) begin
      sc_d  = {SC_WIDTH{1'b0}};
      ovf_d = 1'b1;
    end else begin
      sc_d = sc_q + {{(SC_WIDTH-1){1'b0}}, 1'b1};
    end

    if (bus.ir_load && s_q) begin
      ir_d = bus.ir_in;
    end else begin
      ir_d = ir_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q   <= 1'b0;
      sc_q  <= {SC_WIDTH{1'b0}};
      ir_q  <= {IR_WIDTH{1'b0}};
      ovf_q <= 1'b0;
    end else begin
      s_q   <= s_d;
      sc_q  <= sc_d;
      ir_q  <= ir_d;
      ovf_q <= ovf_d;
    end
  end

  // Decoded outputs are purely functions of registered state.
  always_comb begin
    if (s_q) begin
      bus.T = {{(T_WIDTH-1){1'b0}}, 1'b1} << sc_q;
    end else begin
      bus.T = {T_WIDTH{1'b0}};
    end
    bus.D           = 8'b0000_0001 << ir_q[IR_WIDTH-2 -: 3];
    bus.J           = ir_q[IR_WIDTH-1];
    bus.ir_addr     = ir_q[11:0];
    bus.running     = s_q;
    bus.sc_overflow = ovf_q;
  end
endmodule

// File: tb/tb_timing_control_unit.sv
// Scoreboard bench for timing_control_unit: a behavioural model pushes expected outputs
// when stimulus is driven; they are popped and compared after the DUT clock edge.
module tb_timing_control_unit;
  typedef struct packed {
    logic [7:0]  t;
    logic [7:0]  d;
    logic        j;
    logic [11:0] addr;
    logic        run;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];

  // behavioural model state
  logic        m_s;
  logic [2:0]  m_sc;
  logic [15:0] m_ir;
  logic        m_ovf;

  timing_control_unit_if #(.SC_WIDTH(3), .IR_WIDTH(16)) bus ();

  timing_control_unit #(.SC_WIDTH(3), .IR_WIDTH(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, advance the model, then check the DUT after the edge.
  task automatic step(input logic rst, input logic st, input logic hl, input logic clr,
                      input logic ld, input logic [15:0] din);
    exp_t       e;
    logic       ns;
    logic [2:0] nsc;
    logic       novf;
    logic [15:0] nir;
    @(negedge clk);
    rst_n       = rst;
    bus.start   = st;
    bus.halt    = hl;
    bus.sc_clr  = clr;
    bus.ir_load = ld;
    bus.ir_in   = din;
    if (!rst) begin
      ns = 1'b0; nsc = 3'd0; nir = 16'h0000; novf = 1'b0;
    end else begin
      novf = m_ovf;
      nir  = (ld && m_s) ? din : m_ir;
      if (hl || !m_s)      nsc = 3'd0;
      else if (clr)        nsc = 3'd0;
      else if (m_sc == 3'd7) begin nsc = 3'd0; novf = 1'b1; end
      else                 nsc = m_sc + 3'd1;
      if (hl)      ns = 1'b0;
      else if (st) ns = 1'b1;
      else         ns = m_s;
    end
    m_s = ns; m_sc = nsc; m_ir = nir; m_ovf = novf;
    e.t    = m_s ? (8'h01 << m_sc) : 8'h00;
    e.d    = 8'h01 << m_ir[14:12];
    e.j    = m_ir[15];
    e.addr = m_ir[11:0];
    e.run  = m_s;
    e.ovf  = m_ovf;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("sb_T",       32'(bus.T),           32'(e.t));
    chk("sb_D",       32'(bus.D),           32'(e.d));
    chk("sb_J",       32'(bus.J),           32'(e.j));
    chk("sb_addr",    32'(bus.ir_addr),     32'(e.addr));
    chk("sb_running", 32'(bus.running),     32'(e.run));
    chk("sb_ovf",     32'(bus.sc_overflow), 32'(e.ovf));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_s = 1'b0; m_sc = 3'd0; m_ir = 16'h0000; m_ovf = 1'b0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.halt = 1'b0; bus.sc_clr = 1'b0; bus.ir_load = 1'b0; bus.ir_in = 16'h0000;

    // reset state
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("rst_T",   32'(bus.T),           32'h00);
    chk("rst_D",   32'(bus.D),           32'h01);
    chk("rst_run", 32'(bus.running),     32'h0);
    chk("rst_ovf", 32'(bus.sc_overflow), 32'h0);

    // first fetch and T stepping
    idle(2);
    chk("idle_T", 32'(bus.T), 32'h00);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("start_run", 32'(bus.running), 32'h1);
    chk("T0", 32'(bus.T), 32'h01);
    idle(1);
    chk("T1", 32'(bus.T), 32'h02);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("T2_start_ignored", 32'(bus.T), 32'h04);

    // IR load at T2, visible during T3
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hB123);
    chk("T3", 32'(bus.T), 32'h08);
    chk("T3_D", 32'(bus.D), 32'h08);
    chk("T3_J", 32'(bus.J), 32'h1);
    chk("T3_addr", 32'(bus.ir_addr), 32'h123);

    // sc_clr at T4
    idle(1);
    chk("T4", 32'(bus.T), 32'h10);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    chk("clr_T0", 32'(bus.T), 32'h01);
    chk("clr_ovf", 32'(bus.sc_overflow), 32'h0);

    // wrap without sc_clr
    idle(7);
    chk("T7", 32'(bus.T), 32'h80);
    chk("pre_wrap_ovf", 32'(bus.sc_overflow), 32'h0);
    idle(1);
    chk("wrap_T0", 32'(bus.T), 32'h01);
    chk("wrap_ovf", 32'(bus.sc_overflow), 32'h1);
    idle(2);
    chk("ovf_sticky", 32'(bus.sc_overflow), 32'h1);
    chk("T2_again", 32'(bus.T), 32'h04);
    idle(1);

    // start+halt at T3: halt wins, IR held, loads ignored while halted
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    chk("halt_run", 32'(bus.running), 32'h0);
    chk("halt_T", 32'(bus.T), 32'h00);
    chk("halt_D", 32'(bus.D), 32'h08);
    chk("halt_J", 32'(bus.J), 32'h1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h7800);
    chk("halted_load_D", 32'(bus.D), 32'h08);
    chk("halted_load_addr", 32'(bus.ir_addr), 32'h123);

    // reset during T5 with IR=7800
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    idle(1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h7800);
    idle(3);
    chk("T5", 32'(bus.T), 32'h20);
    chk("T5_D", 32'(bus.D), 32'h80);
    chk("T5_J", 32'(bus.J), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("mid_rst_T", 32'(bus.T), 32'h00);
    chk("mid_rst_D", 32'(bus.D), 32'h01);
    chk("mid_rst_J", 32'(bus.J), 32'h0);
    chk("mid_rst_run", 32'(bus.running), 32'h0);
    chk("mid_rst_ovf", 32'(bus.sc_overflow), 32'h0);

    // random mix against the model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 59) != 0,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 6) == 0,
           $urandom_range(0, 3) == 0,
           16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
